// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: latch state encoding, per-stage bundle layouts and their widths.
// Every bundle keeps its halt flag in bit 0, so HALT_BIT=0 works for all stages.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PL_EMPTY = 2'd0,
    PL_ONE   = 2'd1,
    PL_TWO   = 2'd2
  } pl_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        halt;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        halt;
  } idex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        halt;
  } exmem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        halt;
  } memwb_t;

  localparam int IFID_W  = $bits(ifid_t);
  localparam int IDEX_W  = $bits(idex_t);
  localparam int EXMEM_W = $bits(exmem_t);
  localparam int MEMWB_W = $bits(memwb_t);

endpackage

// File: rtl/pl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_srst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_srst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_latch_elastic.sv
// Elastic ready/valid pipeline latch with optional 2-entry skid buffer, flush-to-bubble,
// sticky halt lock and a saturating stall counter.
module pipe_latch_elastic
  import cpu_types_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter int                SKID     = 1,
  parameter logic [DATA_W-1:0] BUBBLE   = '0,
  parameter int                HALT_BIT = 0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_cnt
);

  pl_state_t         r_state;
  pl_state_t         w_state_next;
  logic [DATA_W-1:0] r_m;
  logic [DATA_W-1:0] w_m_next;
  logic [DATA_W-1:0] r_s;
  logic [DATA_W-1:0] w_s_next;
  logic              r_halted;
  logic              w_halted_next;
  logic              w_in_ready;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign out_valid  = (r_state != PL_EMPTY);
  assign out_data   = out_valid ? r_m : BUBBLE;
  assign in_ready   = w_in_ready;
  assign halted     = r_halted;
  assign w_in_xfer  = in_valid && w_in_ready;
  assign w_out_xfer = out_valid && out_ready;

  // Flush squashes held bundles and any same-cycle input; the head's output transfer still happened.
  always_comb begin
    w_state_next = r_state;
    w_m_next     = r_m;
    w_s_next     = r_s;
    if (flush) begin
      w_state_next = PL_EMPTY;
    end else if (SKID != 0) begin
      unique case (r_state)
        PL_EMPTY: begin
          if (w_in_xfer) begin
            w_state_next = PL_ONE;
            w_m_next     = in_data;
          end
        end
        PL_ONE: begin
          if (w_in_xfer && !w_out_xfer) begin
            w_state_next = PL_TWO;
            w_s_next     = in_data;
          end else if (!w_in_xfer && w_out_xfer) begin
            w_state_next = PL_EMPTY;
          end else if (w_in_xfer && w_out_xfer) begin
            w_m_next     = in_data;
          end
        end
        PL_TWO: begin
          if (w_out_xfer) begin
            w_state_next = PL_ONE;
            w_m_next     = r_s;
          end
        end
        default: w_state_next = PL_EMPTY;
      endcase
    end else begin
      if (w_in_xfer) begin
        w_state_next = PL_ONE;
        w_m_next     = in_data;
      end else if (w_out_xfer) begin
        w_state_next = PL_EMPTY;
      end
    end
  end

  assign w_halted_next = flush ? 1'b0 : (r_halted || (w_in_xfer && in_data[HALT_BIT]));

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state  <= PL_EMPTY;
      r_m      <= BUBBLE;
      r_s      <= BUBBLE;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_m      <= w_m_next;
      r_s      <= w_s_next;
      r_halted <= w_halted_next;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;

      // Registered ready breaks the combinational out_ready -> in_ready path.
      always_ff @(posedge clk) begin
        if (RST) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_next != PL_TWO) && !w_halted_next;
        end
      end

      assign w_in_ready = r_in_ready;
    end else begin : g_noskid
      assign w_in_ready = (!out_valid || out_ready) && !r_halted;
    end
  endgenerate

  pl_sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .i_srst (RST),
    .i_clr  (clr_cnt),
    .i_inc  (out_valid && !out_ready),
    .o_cnt  (stall_cnt)
  );

endmodule
